// File: rtl/snes_pad_pkg.sv
// snes_pad_pkg: shared state encoding, button bit positions and default timing for the SNES pad poller.
package snes_pad_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    PULSE_LO = 3'd2,
    PULSE_HI = 3'd3,
    DONE     = 3'd4
  } state_e;
  localparam int FRAME_BITS      = 16;
  localparam int CLK_HALF_DEF    = 300;
  localparam int POLL_CYCLES_DEF = 833333;
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;
endpackage

// File: rtl/snes_pad_reader_pad_sync.sv
// pad_sync: two-flop synchronizer for the pad data lines; resets to the idle-high line level.
module pad_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end
  assign o_q = r_s2;
endmodule

// File: rtl/snes_pad_reader.sv
// snes_pad_reader: polls two SNES pads in parallel and presents their 16-bit button words.
// Define PAD_SYNC_EN to route pad_data through a two-flop synchronizer before sampling.
module snes_pad_reader
  import snes_pad_pkg::*;
#(
  parameter int CLK_HALF    = CLK_HALF_DEF,
  parameter int POLL_CYCLES = POLL_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [15:0] p1_buttons,
  output logic [15:0] p2_buttons,
  output logic        frame_valid
);
  localparam int CW = $clog2(2 * CLK_HALF);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_HALF - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

  state_e      r_state;
  state_e      w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_idx;
  logic [PW-1:0] r_poll;
  logic [15:0] r_sh1;
  logic [15:0] r_sh2;
  logic [15:0] r_p1;
  logic [15:0] r_p2;
  logic        r_latch;
  logic        r_clk;
  logic        r_valid;
  logic [1:0]  w_data;
  logic        w_tick;
  logic        w_cnt_done;

`ifdef PAD_SYNC_EN
  pad_sync #(.WIDTH(2)) u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (pad_data),
    .o_q   (w_data)
  );
`else
  assign w_data = pad_data;
`endif

  assign w_tick     = r_poll == POLL_LAST;
  assign w_cnt_done = r_cnt == ((r_state == LATCH) ? LATCH_LAST : HALF_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_tick && enable) w_next = LATCH;
      LATCH:    if (w_cnt_done) w_next = PULSE_LO;
      PULSE_LO: if (w_cnt_done) w_next = PULSE_HI;
      PULSE_HI: if (w_cnt_done) w_next = (r_idx == 4'd15) ? DONE : PULSE_LO;
      default:  w_next = IDLE;
    endcase
  end

  // pin outputs are registered from the next state so they move on the same edge as the FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_poll  <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_p1    <= '0;
      r_p2    <= '0;
      r_latch <= 1'b0;
      r_clk   <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_poll  <= w_tick ? '0 : r_poll + 1'b1;
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE || w_cnt_done) ? '0 : r_cnt + 1'b1;
      r_idx   <= (r_state == LATCH) ? '0 : (r_state == PULSE_HI && w_cnt_done) ? r_idx + 1'b1 : r_idx;
      if (r_state == PULSE_LO && w_cnt_done) begin
        r_sh1[r_idx] <= w_data[0];
        r_sh2[r_idx] <= w_data[1];
      end
      if (r_state == DONE) begin
        r_p1 <= ~r_sh1;
        r_p2 <= ~r_sh2;
      end
      r_valid <= r_state == DONE;
      r_latch <= w_next == LATCH;
      r_clk   <= w_next != PULSE_LO;
    end
  end

  assign pad_latch   = r_latch;
  assign pad_clk     = r_clk;
  assign p1_buttons  = r_p1;
  assign p2_buttons  = r_p2;
  assign frame_valid = r_valid;
endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader: table-driven and randomized frame checks against a cycle-history pad model.
module tb_snes_pad_reader;
  localparam int H = 4;
  localparam int P = 200;
`ifdef PAD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic [15:0] p1_buttons;
  logic [15:0] p2_buttons;
  logic        frame_valid;

  always #5 clock = ~clock;

  snes_pad_reader #(.CLK_HALF(H), .POLL_CYCLES(P)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .pad_data    (pad_data),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .p1_buttons  (p1_buttons),
    .p2_buttons  (p2_buttons),
    .frame_valid (frame_valid)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [1:0] hist [0:16383];

  // hist[n] is the pad_data level just before the edge that ends cycle n
  always @(posedge clock) begin
    hist[cyc % 16384] <= pad_data;
    cyc <= cyc + 1;
  end

  logic [15:0] pat1 = 16'hFFFF;
  logic [15:0] pat2 = 16'hFFFF;
  int          pidx = 16;
  logic        use_model = 1'b1;
  logic [1:0]  drv = 2'b11;

  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pidx <= 0;
    else pidx <= (pidx < 16) ? pidx + 1 : 16;
  end

  assign pad_data = use_model ? {(pidx < 16) ? pat2[pidx[3:0]] : 1'b1, (pidx < 16) ? pat1[pidx[3:0]] : 1'b1} : drv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wait_latch(output int l);
    int t = 0;
    while (pad_latch !== 1'b1 && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (pad_latch !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL latch_timeout actual=no_latch expected=latch");
      l = -1;
    end else l = cyc;
  endtask

  task automatic check_frame(input int l, input logic [15:0] e1, input logic [15:0] e2, input logic use_e,
                             input int drop_o, input int poke_o, input logic noise, input string nm);
    logic [15:0] m1, m2, old1, old2;
    logic        exp_clk;
    int          bad = 0;
    int          s;
    old1 = p1_buttons;
    old2 = p2_buttons;
    for (int o = 0; o <= 138; o++) begin
      exp_clk = (o >= 8 && o < 136) ? (((o - 8) % 8) >= H) : 1'b1;
      if (pad_latch !== (o < 8) || pad_clk !== exp_clk || frame_valid !== (o == 137)) bad++;
      if (o < 137 && (p1_buttons !== old1 || p2_buttons !== old2)) bad++;
      if (o == 137) begin
        for (int k = 0; k < 16; k++) begin
          s = l + 2 * H + 2 * H * k + H - 1 - LAT;
          m1[k] = ~hist[s % 16384][0];
          m2[k] = ~hist[s % 16384][1];
        end
        chk({nm, "_model_p1"}, 32'(p1_buttons), 32'(m1));
        chk({nm, "_model_p2"}, 32'(p2_buttons), 32'(m2));
        if (use_e) begin
          chk({nm, "_p1"}, 32'(p1_buttons), 32'(e1));
          chk({nm, "_p2"}, 32'(p2_buttons), 32'(e2));
        end
      end
      if (o == drop_o) enable = 1'b0;
      if (o == poke_o) drv[0] = 1'b0;
      if (o == poke_o + 1) drv[0] = 1'b1;
      if (noise) drv = 2'($urandom);
      @(negedge clock);
    end
    chk({nm, "_wave"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int   l, prev_l, c0, nl, hold_bad;
    logic [15:0] h1, h2;
    tbl[0] = '{16'hFFFE, 16'h7FFF, 16'h0001, 16'h8000};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[2] = '{16'hFFF7, 16'hFFFF, 16'h0008, 16'h0000};
    for (int i = 3; i < 7; i++) begin
      tbl[i].p1 = 16'($urandom);
      tbl[i].p2 = 16'($urandom);
      tbl[i].e1 = ~tbl[i].p1;
      tbl[i].e2 = ~tbl[i].p2;
    end
    repeat (3) @(negedge clock);
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_clk", 32'(pad_clk), 32'd1);
    chk("rst_p1", 32'(p1_buttons), 32'd0);
    chk("rst_p2", 32'(p2_buttons), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    c0 = cyc;
    wait_latch(l);
    chk("first_latch_delay", 32'(l - c0), 32'd200);
    prev_l = l;
    for (int i = 0; i < 7; i++) begin
      if (l < 0) break;
      if (i > 0) begin
        wait_latch(l);
        if (l < 0) break;
        chk("frame_spacing", 32'(l - prev_l), 32'd200);
        prev_l = l;
      end
      pat1 = tbl[i].p1;
      pat2 = tbl[i].p2;
      check_frame(l, tbl[i].e1, tbl[i].e2, 1'b1, -10, -10, 1'b0, $sformatf("vec%0d", i));
    end
    use_model = 1'b0;
    wait_latch(l);
    if (l >= 0) check_frame(l, 16'h0, 16'h0, 1'b0, -10, -10, 1'b1, "noise");
    drv = 2'b11;
    use_model = 1'b1;
    pat1 = 16'($urandom);
    pat2 = 16'($urandom);
    wait_latch(l);
    if (l >= 0) check_frame(l, ~pat1, ~pat2, 1'b1, 2 * H + 2 * H * 5 + 1, -10, 1'b0, "drop_en");
    h1 = p1_buttons;
    h2 = p2_buttons;
    nl = 0;
    hold_bad = 0;
    repeat (1000) begin
      @(negedge clock);
      if (pad_latch) nl++;
      if (p1_buttons !== h1 || p2_buttons !== h2 || frame_valid !== 1'b0) hold_bad++;
    end
    chk("no_latch_after_drop", 32'(nl), 32'd0);
    chk("hold_after_drop", 32'(hold_bad), 32'd0);
    enable = 1'b1;
    wait_latch(l);
    repeat (2 * H + 2 * H * 10 + 2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_clk", 32'(pad_clk), 32'd1);
    chk("midrst_latch", 32'(pad_latch), 32'd0);
    chk("midrst_p1", 32'(p1_buttons), 32'd0);
    chk("midrst_p2", 32'(p2_buttons), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    c0 = cyc;
    pat1 = 16'($urandom);
    pat2 = 16'($urandom);
    wait_latch(l);
    if (l >= 0) begin
      chk("latch_after_midrst", 32'(l - c0), 32'd200);
      check_frame(l, ~pat1, ~pat2, 1'b1, -10, -10, 1'b0, "post_rst");
    end
    use_model = 1'b0;
    drv = 2'b11;
    wait_latch(l);
    if (l >= 0) check_frame(l, (LAT > 0) ? 16'h0000 : 16'h0008, 16'h0000, 1'b1, -10, 2 * H + 2 * H * 3 + H - 1, 1'b0, "late_edge");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snes_pad_reader.md
# snes_pad_reader

Serial controller poller that drives the latch/clock side of the SNES-style pad protocol and shifts in button state from two pads in parallel. It sits between the board GPIO pins and the memory-mapped IO block: its latch and clock outputs go to the pad connectors, its serial inputs come from the pads' data lines, and it presents two 16-bit button words that the processor reads through mmio.

## Interface

Parameters:
- CLK_HALF, 300 — clock cycles per protocol half-period (6 µs at 50 MHz); legal minimum 4.
- POLL_CYCLES, 833333 — cycles between frame starts (60 Hz); must be ≥ 34*CLK_HALF + 2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- enable  in  1  1 = start frames on poll ticks; 0 = no new frames.
- pad_data  in  2  serial data; bit 0 = player 1, bit 1 = player 2; active-low.
- pad_latch  out  1  latch strobe to both pads; goes to gpioOutput[0].
- pad_clk  out  1  shift clock to both pads, idles high; goes to gpioOutput[1].
- p1_buttons  out  16  player 1 buttons, 1 = pressed.
- p2_buttons  out  16  player 2 buttons, 1 = pressed.
- frame_valid  out  1  one-cycle pulse when both button words update.

## Operation

- States: IDLE, LATCH, PULSE_LO, PULSE_HI, DONE.
- Poll counter: free-running, counts 0..POLL_CYCLES-1 and wraps; a tick is asserted when it equals POLL_CYCLES-1.
- IDLE: pad_latch=0, pad_clk=1. On a tick with enable=1, go to LATCH.
- LATCH: pad_latch=1 for 2*CLK_HALF cycles, then go to PULSE_LO with bit index 0.
- PULSE_LO: pad_clk=0 for CLK_HALF cycles. On the last cycle, sample (synchronized) pad_data into shift bit k = index. Then go to PULSE_HI.
- PULSE_HI: pad_clk=1 for CLK_HALF cycles. The rising edge advances the pad to bit k+1. If index=15, go to DONE; otherwise increment index and go to PULSE_LO.
- DONE: for one cycle, set p1_buttons = ~shift1 and p2_buttons = ~shift2, assert frame_valid=1, then go to IDLE.
- Bit order (serial bit k → output bit k): 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12–15 ID.
- Button words change only in DONE. They hold their value between frames and while enable=0.
- Clearing enable mid-frame: the current frame completes normally; no further frames start.
- A tick that arrives outside IDLE is ignored. The POLL_CYCLES constraint makes this unreachable.

## Timing

- Reset values: pad_latch=0, pad_clk=1, p1_buttons=0, p2_buttons=0, frame_valid=0, state IDLE, poll counter 0, shift registers 0.
- First tick occurs POLL_CYCLES-1 cycles after reset release. pad_latch rises on the following edge.
- Frame length, latch rise to frame_valid: 2*CLK_HALF + 32*CLK_HALF cycles, plus 1 cycle for DONE.
- Frame starts are exactly POLL_CYCLES cycles apart while enable=1.
- Reset asserted mid-frame: outputs return to reset values asynchronously. The partial frame is discarded.
- pad_latch and pad_clk are registered outputs and never glitch.

## Configuration

- PAD_SYNC_EN defined: pad_data passes through a two-flop synchronizer per bit before sampling. The sampled value is pad_data as it stood 2 cycles before the sample cycle.
- PAD_SYNC_EN undefined: pad_data is sampled directly, with zero added latency. Use only in simulation or with externally synchronized inputs.
- Frame timing and outputs are otherwise identical in both modes.

## Structure

- Package snes_pad_pkg holds:
  - state enum (IDLE, LATCH, PULSE_LO, PULSE_HI, DONE);
  - button index constants (BTN_B … BTN_R);
  - default CLK_HALF and POLL_CYCLES constants;
  - FRAME_BITS = 16.
- One sub-module: pad_sync, a two-flop synchronizer with parameterized width. It is instantiated only under PAD_SYNC_EN.
- Half-period counter, bit index, poll counter, and the two shift registers live in the top module.

## Test plan

Bench parameters: CLK_HALF=4, POLL_CYCLES=200, PAD_SYNC_EN defined.

- Reset, then hold enable=1 → pad_latch rises 200 cycles after reset release and stays high 8 cycles, then 16 low/high pulses of 4+4 cycles; frame_valid pulses once, 137 cycles after latch rise.
- Pad model for p1 drives serial pattern 0xFFFE (B pressed), p2 drives 0x7FFF (bit 15 low) → p1_buttons=0x0001, p2_buttons=0x8000 on frame_valid.
- Both pads held all-high, i.e. nothing pressed → both words 0x0000; next frame with p1 Start low → p1_buttons=0x0008, changing only on the frame_valid cycle.
- enable=1 for one frame, then deassert during pulse 5 → that frame completes and frame_valid fires; no pad_latch for the next 1000 cycles; outputs hold.
- Assert reset during pulse 10 → same cycle: pad_clk=1, pad_latch=0, words 0; after release, next latch 200 cycles later.
- Data changing 1 cycle before sample edge with sync enabled → old value captured; same stimulus with PAD_SYNC_EN undefined → new value captured.
